// File: rtl/axi_full_pkg.sv
// axi_full_pkg: shared AXI4 constants, loader enums and the 4 KB crossing test
package axi_full_pkg;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_16B    = 3'd4;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {ERR_OK, ERR_RESP, ERR_PROTO, ERR_REJ} err_e;
  typedef enum logic [2:0] {S_IDLE, S_CHK, S_AWR, S_WDAT, S_BRSP, S_ARD, S_RDAT, S_RET} state_e;
  function automatic logic crosses_4k(input logic [11:0] off, input logic [7:0] len);
    logic [13:0] sum;
    sum = {2'b0, off} + {1'b0, {1'b0, len} + 9'd1, 4'b0};
    return sum > 14'd4096;
  endfunction
endpackage

// File: rtl/axi_beat_cnt.sv
// axi_beat_cnt: burst beat counter with compare against the latched AXI LEN
module axi_beat_cnt (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       clr,
  input  logic       inc,
  input  logic [7:0] len,
  output logic [7:0] cnt,
  output logic       last
);
  // count accepted beats, cleared before each burst starts
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 8'd1;
  assign last = cnt == len;
endmodule

// File: rtl/axi_full_mst_loader.sv
// axi_full_mst_loader: AXI4 burst initiator turning single commands plus a data stream into AW/W/B or AR/R bursts
module axi_full_mst_loader
  import axi_full_pkg::*;
#(
  parameter int DW  = 128,
  parameter int AW  = 32,
  parameter int IDW = 4
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_wr,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [7:0]      cmd_len,
  input  logic [IDW-1:0]  cmd_id,
  input  logic            src_valid,
  output logic            src_ready,
  input  logic [DW-1:0]   src_data,
  input  logic [DW/8-1:0] src_strb,
  output logic            snk_valid,
  input  logic            snk_ready,
  output logic [DW-1:0]   snk_data,
  output logic            snk_last,
  output logic            done,
  output logic [1:0]      err,
  output logic            busy,
  output logic [IDW-1:0]  MEM_AWID,
  output logic [AW-1:0]   MEM_AWADDR,
  output logic [7:0]      MEM_AWLEN,
  output logic [2:0]      MEM_AWSIZE,
  output logic [1:0]      MEM_AWBURST,
  output logic            MEM_AWVALID,
  input  logic            MEM_AWREADY,
  output logic [DW-1:0]   MEM_WDATA,
  output logic [DW/8-1:0] MEM_WSTRB,
  output logic            MEM_WLAST,
  output logic            MEM_WVALID,
  input  logic            MEM_WREADY,
  input  logic [IDW-1:0]  MEM_BID,
  input  logic [1:0]      MEM_BRESP,
  input  logic            MEM_BVALID,
  output logic            MEM_BREADY,
  output logic [IDW-1:0]  MEM_ARID,
  output logic [AW-1:0]   MEM_ARADDR,
  output logic [7:0]      MEM_ARLEN,
  output logic [2:0]      MEM_ARSIZE,
  output logic [1:0]      MEM_ARBURST,
  output logic            MEM_ARVALID,
  input  logic            MEM_ARREADY,
  input  logic [IDW-1:0]  MEM_RID,
  input  logic [DW-1:0]   MEM_RDATA,
  input  logic [1:0]      MEM_RRESP,
  input  logic            MEM_RLAST,
  input  logic            MEM_RVALID,
  output logic            MEM_RREADY
);
  state_e state, nxt;
  err_e err_q;
  logic wr_q, w_hs, r_hs, proto, last, rej;
  logic [AW-1:0] addr_q;
  logic [7:0] len_q, cnt;
  logic [IDW-1:0] id_q;
  assign w_hs  = state == S_WDAT && src_valid && MEM_WREADY;
  assign r_hs  = state == S_RDAT && MEM_RVALID && snk_ready;
  assign proto = MEM_RLAST != last;
  assign rej   = crosses_4k(addr_q[11:0], len_q);
  axi_beat_cnt u_cnt (
    .CLK (CLK),
    .RSTn(RSTn),
    .clr (state == S_CHK),
    .inc (w_hs || r_hs),
    .len (len_q),
    .cnt (cnt),
    .last(last)
  );
  // state register; reset abandons any burst in flight
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) state <= S_IDLE;
    else state <= nxt;
  // next-state: one command at a time, retire via RET on completion, error or rejection
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (cmd_valid) nxt = S_CHK;
      S_CHK:   nxt = rej ? S_RET : wr_q ? S_AWR : S_ARD;
      S_AWR:   if (MEM_AWREADY) nxt = S_WDAT;
      S_WDAT:  if (w_hs && last) nxt = S_BRSP;
      S_BRSP:  if (MEM_BVALID) nxt = S_RET;
      S_ARD:   if (MEM_ARREADY) nxt = S_RDAT;
      S_RDAT:  if (r_hs && (last || MEM_RLAST)) nxt = S_RET;
      default: nxt = S_IDLE;
    endcase
  end
  // command latch and error tracking; a protocol error outranks a response error
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      len_q  <= '0;
      id_q   <= '0;
      err_q  <= ERR_OK;
    end else begin
      if (state == S_IDLE && cmd_valid) begin
        wr_q   <= cmd_wr;
        addr_q <= cmd_addr & {{(AW-4){1'b1}}, 4'h0};
        len_q  <= cmd_len;
        id_q   <= cmd_id;
        err_q  <= ERR_OK;
      end
      if (state == S_CHK && rej) err_q <= ERR_REJ;
      if (state == S_BRSP && MEM_BVALID)
        err_q <= (MEM_BRESP != RESP_OKAY || MEM_BID != id_q) ? ERR_RESP : ERR_OK;
      if (r_hs)
        err_q <= proto ? ERR_PROTO : (MEM_RRESP != RESP_OKAY || MEM_RID != id_q) ? ERR_RESP : err_q;
    end
  // channel handshakes decoded from state only, so no VALID waits on its READY
  always_comb begin
    cmd_ready   = RSTn && state == S_IDLE;
    busy        = state != S_IDLE;
    done        = state == S_RET;
    MEM_AWVALID = state == S_AWR;
    MEM_WVALID  = state == S_WDAT && src_valid;
    src_ready   = state == S_WDAT && MEM_WREADY;
    MEM_WLAST   = state == S_WDAT && last;
    MEM_BREADY  = state == S_BRSP;
    MEM_ARVALID = state == S_ARD;
    snk_valid   = state == S_RDAT && MEM_RVALID;
    MEM_RREADY  = state == S_RDAT && snk_ready;
    snk_last    = state == S_RDAT && last;
  end
  assign err         = err_q;
  assign MEM_AWID    = id_q;
  assign MEM_AWADDR  = addr_q;
  assign MEM_AWLEN   = len_q;
  assign MEM_AWSIZE  = SIZE_16B;
  assign MEM_AWBURST = BURST_INCR;
  assign MEM_ARID    = id_q;
  assign MEM_ARADDR  = addr_q;
  assign MEM_ARLEN   = len_q;
  assign MEM_ARSIZE  = SIZE_16B;
  assign MEM_ARBURST = BURST_INCR;
  assign MEM_WDATA   = src_data;
  assign MEM_WSTRB   = src_strb;
  assign snk_data    = MEM_RDATA;
endmodule
